// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the memory read/write port arbiter.
package mem_arb_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam int MAX_PORTS = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder; the first requester at or after i_base wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_base,
    output logic [IW-1:0] o_grant,
    output logic          o_any
);

    logic [IW:0] w_sum;

    assign o_any = |i_req;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        o_grant = '0;
        w_sum = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_base} + (IW + 1)'(i);
            if (w_sum >= (IW + 1)'(N)) w_sum = w_sum - (IW + 1)'(N);
            if (i_req[w_sum[IW-1:0]]) o_grant = w_sum[IW-1:0];
        end
    end

endmodule

// File: rtl/mem_rwport_arb.sv
// mem_rwport_arb: N-to-1 arbiter sharing one val/wen/addr/wdata/rdata/rdy memory port,
// with a registered command stage and round-robin or fixed-priority selection.
module mem_rwport_arb
    import mem_arb_pkg::*;
#(
    parameter int        N_PORTS = 2,
    parameter int        AW      = 8,
    parameter int        DW      = 16,
    parameter arb_mode_e MODE    = ARB_RR,
    localparam int       IW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    m_val,
    input  logic [N_PORTS-1:0]    m_wen,
    input  logic [N_PORTS*AW-1:0] m_addr,
    input  logic [N_PORTS*DW-1:0] m_wdata,
    output logic [DW-1:0]         m_rdata,
    output logic [N_PORTS-1:0]    m_rdy,
    output logic                  s_val,
    output logic                  s_wen,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic [DW-1:0]         s_rdata,
    input  logic                  s_rdy
);

    if (N_PORTS < 1 || N_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("mem_rwport_arb: N_PORTS out of range");
    end

    arb_state_e    r_state, w_next;
    logic [IW-1:0] r_ptr, r_gnt, w_gnt, w_base;
    logic          r_wen, w_any, w_done;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    assign w_base  = (MODE == ARB_FIXED) ? '0 : r_ptr;
    assign w_done  = (r_state == BUSY) && s_rdy;
    assign s_val   = (r_state == BUSY);
    assign s_wen   = r_wen;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign m_rdata = s_rdata;
    assign m_rdy   = w_done ? N_PORTS'(1) << r_gnt : '0;

    rr_pick #(.N(N_PORTS)) u_pick (
        .i_req  (m_val),
        .i_base (w_base),
        .o_grant(w_gnt),
        .o_any  (w_any)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_any) w_next = BUSY;
        if (w_done) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_gnt   <= w_gnt;
                r_wen   <= m_wen[w_gnt];
                r_addr  <= m_addr[int'(w_gnt) * AW +: AW];
                r_wdata <= m_wdata[int'(w_gnt) * DW +: DW];
            end
            if (w_done && MODE == ARB_RR)
                r_ptr <= (r_gnt == IW'(N_PORTS - 1)) ? '0 : r_gnt + 1'b1;
        end
    end

endmodule

// File: doc/mem_rwport_arb.md
# mem_rwport_arb

Parametrised N-to-1 arbiter that lets several memory masters share one single-ported memory slave using the val/wen/addr/wdata/rdata/rdy read-write port protocol. It generalises the fixed 8-bit-address, 16-bit-data port to configurable address and data widths and channel count. It adds round-robin or fixed-priority arbitration with a registered command stage. It sits between the CPU-side masters (fetch, load/store, front-panel/DMA) and the main memory.

## Interface
- `N_PORTS`, default 2: number of masters; legal range 1..8.
- `AW`, default 8: address width.
- `DW`, default 16: data width.
- `MODE`, default `ARB_RR`: arbitration policy; `ARB_RR` (round-robin) or `ARB_FIXED` (port 0 highest priority).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_val` in N_PORTS: per-master request valid.
- `m_wen` in N_PORTS: per-master write enable (1 = write, 0 = read).
- `m_addr` in N_PORTS*AW: packed addresses; master i uses bits [i*AW +: AW].
- `m_wdata` in N_PORTS*DW: packed write data.
- `m_rdata` out DW: read data, broadcast to all masters; meaningful only in the cycle a master's `m_rdy` is high.
- `m_rdy` out N_PORTS: per-master completion pulse.
- `s_val` out 1: request to the slave.
- `s_wen` out 1: write enable to the slave.
- `s_addr` out AW: address to the slave.
- `s_wdata` out DW: write data to the slave.
- `s_rdata` in DW: read data from the slave.
- `s_rdy` in 1: slave completion pulse.

## Operation
- **Protocol, both sides.** A requester raises val with wen, addr and wdata, and holds them stable until rdy is sampled high. rdy is high for exactly one cycle per transaction. For reads, rdata is valid in that same cycle. The requester may drop val or issue a new request in the cycle after rdy.
- **State machine.** Two states, IDLE and BUSY.
- **IDLE.**
  - If any `m_val` bit is set, pick a winner g.
  - Capture `m_wen[g]`, `m_addr[g]` and `m_wdata[g]` into the `s_*` registers.
  - Store g and go to BUSY.
  - If no bit is set, stay in IDLE.
- **BUSY.**
  - `s_val`=1; the `s_*` command registers hold.
  - When `s_rdy`=1: `m_rdy[g]`=1 combinationally in the same cycle, and `m_rdata`=`s_rdata`.
  - Then go to IDLE. Under `ARB_RR`, the round-robin pointer becomes (g+1) mod N_PORTS.
- **ARB_RR winner.** The first requesting index at or after the pointer, wrapping past N_PORTS-1 to 0. The pointer resets to 0.
- **ARB_FIXED winner.** The lowest requesting index. The pointer is unused.
- **Master drops `m_val` while BUSY (protocol violation).** The captured command still completes and `m_rdy[g]` still pulses.
- **Non-granted masters.** Their requests wait; they never see `m_rdy` until granted.
- **N_PORTS=1.** Degenerates to a one-cycle registered pass-through.
- **Reset values.** `s_val`=0, `s_wen`=0, `s_addr`=0, `s_wdata`=0, `m_rdy`=0, state IDLE, pointer 0, stored g=0.
- **Reset mid-BUSY.** The transaction is abandoned and no `m_rdy` is issued. The slave shares `rst` and must abandon it too.

## Timing
- **Request to slave.** `m_val` seen at edge k in IDLE gives `s_val`=1 from cycle k+1.
- **Slave to master.** `s_rdy` to `m_rdy` is 0 cycles (combinational).
- **Throughput.** One mandatory IDLE cycle follows each completion. Back-to-back transactions therefore cost slave latency plus 2 cycles each.
- **Slave during completion.** `s_val` is still 1 in the `s_rdy` cycle and 0 in the following IDLE cycle.
- **Simultaneous requests and completion.** New requests arriving in the `s_rdy` cycle are not arbitrated until the IDLE cycle that follows.
- **Combinational path.** The only combinational path from inputs to outputs is `s_rdy`/`s_rdata` to `m_rdy`/`m_rdata`.

## Structure
- **Package `mem_arb_pkg`.**
  - `arb_mode_e` enum with `ARB_RR` and `ARB_FIXED`.
  - `arb_state_e` enum with `IDLE` and `BUSY`.
  - Constant `MAX_PORTS`=8.
- **Sub-module `rr_pick`.**
  - Parameter N.
  - Inputs: req[N], base index.
  - Outputs: grant index, any-request flag.
  - Combinational rotating priority encoder. `ARB_FIXED` drives base=0.
- **Top level.** The state register, pointer, grant register and command registers live in `mem_rwport_arb`.

## Test plan
- **Single read.** N_PORTS=2, AW=8, DW=16, slave rdy latency 1. Port 1 reads addr 0x3C, slave returns 0xBEEF -> `s_val` at cycle 1, `s_addr`=0x3C, `m_rdy[1]` pulses with `m_rdata`=0xBEEF, and `m_rdy[0]` stays 0.
- **Round-robin.** Ports 0 and 1 hold continuous requests under `ARB_RR` -> grants alternate 0,1,0,1. Each transaction is separated by one IDLE cycle.
- **Fixed priority.** Same stimulus under `ARB_FIXED` -> port 0 is granted every time, and port 1 is granted only once port 0 drops val.
- **Four ports, wrap-around.** N_PORTS=4 under `ARB_RR`, pointer=3, requests on ports 1 and 2 only -> port 1 wins, then the pointer becomes 2.
- **Write then read-back.** A write to addr 0xFF with data 0x1234, followed by a read of 0xFF, against a model RAM -> read returns 0x1234. Also check that `s_wen` is 1 during the write's BUSY and 0 during the read's.
- **Reset mid-transaction.** `rst` asserted during BUSY with a slave latency of 5 -> the next cycle has `s_val`=0 and all `m_rdy`=0, the pointer is 0, and a fresh request completes normally.
